memory_stage: RTL and testbench

//   Pipeline stage 4; sits between execute and writeback_stage.

---
 rtl/memory_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_memory_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Pipeline stage 4: runs the data-memory access for one execute result at a time
// and emits exactly one single-cycle result beat per instruction to writeback.
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [63:0] ex_result,
  input  logic [63:0] ex_store_data,
  input  logic [1:0]  ex_mem_op,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_write_to_rd,
  input  logic        ex_is_branch_addr,
  input  logic        ex_end_program,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] mem_result,
  output logic        mem_result_valid,
  output logic        result_is_branch_addr,
  output logic        write_to_rd,
  output logic [4:0]  rd,
  output logic        should_end_program,
  output logic        mem_fault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Latched instruction for the duration of a memory access
  logic [63:0] op_addr_reg, op_addr_next;
  logic [63:0] op_data_reg, op_data_next;
  logic        op_store_reg, op_store_next;
  logic [2:0]  op_funct3_reg, op_funct3_next;
  logic [4:0]  op_rd_reg, op_rd_next;
  logic        op_wr_reg, op_wr_next;
  logic        op_br_reg, op_br_next;
  logic        op_end_reg, op_end_next;

  logic [63:0] result_reg, result_next;
  logic        valid_reg, valid_next;
  logic        br_reg, br_next;
  logic        wr_reg, wr_next;
  logic [4:0]  rd_reg, rd_next;
  logic        end_reg, end_next;
  logic        fault_reg, fault_next;

  logic        ex_is_mem;
  logic        req_active;
  logic [63:0] shifted;
  logic [63:0] load_val;
  logic [7:0]  strb_base;

  function automatic logic misaligned(input logic [2:0] a, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a[2:0];
    endcase
  endfunction

  assign ex_is_mem  = (ex_mem_op == 2'd1) || (ex_mem_op == 2'd2);
  assign ex_ready   = (state_reg == S_IDLE);
  assign req_active = (state_reg == S_REQ);

  always_comb begin
    strb_base = 8'h01;
    case (op_funct3_reg[1:0])
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  // dmem outputs are quiet outside REQ so the bus sees nothing stale
  assign dmem_req   = req_active;
  assign dmem_we    = req_active && op_store_reg;
  assign dmem_addr  = req_active ? {op_addr_reg[63:3], 3'b000} : 64'd0;
  assign dmem_wdata = (req_active && op_store_reg) ?
                      (op_data_reg << {op_addr_reg[2:0], 3'b000}) : 64'd0;
  assign dmem_wstrb = (req_active && op_store_reg) ? (strb_base << op_addr_reg[2:0]) : 8'd0;

  assign shifted = dmem_rdata >> {op_addr_reg[2:0], 3'b000};

  always_comb begin
    load_val = shifted;
    case (op_funct3_reg)
      3'd0:    load_val = {{56{shifted[7]}},  shifted[7:0]};
      3'd1:    load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'd2:    load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'd4:    load_val = {56'd0, shifted[7:0]};
      3'd5:    load_val = {48'd0, shifted[15:0]};
      3'd6:    load_val = {32'd0, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_addr_next   = op_addr_reg;
    op_data_next   = op_data_reg;
    op_store_next  = op_store_reg;
    op_funct3_next = op_funct3_reg;
    op_rd_next     = op_rd_reg;
    op_wr_next     = op_wr_reg;
    op_br_next     = op_br_reg;
    op_end_next    = op_end_reg;
    result_next    = result_reg;
    valid_next     = 1'b0;
    br_next        = br_reg;
    wr_next        = wr_reg;
    rd_next        = rd_reg;
    end_next       = end_reg;
    fault_next     = fault_reg;

    case (state_reg)
      S_IDLE: begin
        if (ex_valid) begin
          op_addr_next   = ex_result;
          op_data_next   = ex_store_data;
          op_store_next  = (ex_mem_op == 2'd2);
          op_funct3_next = ex_funct3;
          op_rd_next     = ex_rd;
          op_wr_next     = ex_write_to_rd;
          op_br_next     = ex_is_branch_addr;
          op_end_next    = ex_end_program;
          if (ex_is_mem && misaligned(ex_result[2:0], ex_funct3[1:0])) begin
            valid_next  = 1'b1;
            result_next = ex_result;
            br_next     = ex_is_branch_addr;
            wr_next     = 1'b0;
            rd_next     = ex_rd;
            end_next    = 1'b1;
            fault_next  = 1'b1;
          end else if (ex_is_mem) begin
            state_next = S_REQ;
          end else begin
            valid_next  = 1'b1;
            result_next = ex_result;
            br_next     = ex_is_branch_addr;
            wr_next     = ex_write_to_rd;
            rd_next     = ex_rd;
            end_next    = ex_end_program;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          if (op_store_reg) begin
            state_next  = S_IDLE;
            valid_next  = 1'b1;
            result_next = op_addr_reg;
            br_next     = op_br_reg;
            wr_next     = 1'b0;
            rd_next     = op_rd_reg;
            end_next    = op_end_reg;
          end else begin
            state_next = S_WAIT;
            cnt_next   = '0;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          state_next  = S_IDLE;
          valid_next  = 1'b1;
          result_next = load_val;
          br_next     = op_br_reg;
          wr_next     = op_wr_reg;
          rd_next     = op_rd_reg;
          end_next    = op_end_reg;
        end else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
          // Bus timeout retires the load as a fault beat
          state_next  = S_IDLE;
          valid_next  = 1'b1;
          result_next = op_addr_reg;
          br_next     = op_br_reg;
          wr_next     = 1'b0;
          rd_next     = op_rd_reg;
          end_next    = 1'b1;
          fault_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      op_addr_reg   <= '0;
      op_data_reg   <= '0;
      op_store_reg  <= 1'b0;
      op_funct3_reg <= '0;
      op_rd_reg     <= '0;
      op_wr_reg     <= 1'b0;
      op_br_reg     <= 1'b0;
      op_end_reg    <= 1'b0;
      result_reg    <= '0;
      valid_reg     <= 1'b0;
      br_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      rd_reg        <= '0;
      end_reg       <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_addr_reg   <= op_addr_next;
      op_data_reg   <= op_data_next;
      op_store_reg  <= op_store_next;
      op_funct3_reg <= op_funct3_next;
      op_rd_reg     <= op_rd_next;
      op_wr_reg     <= op_wr_next;
      op_br_reg     <= op_br_next;
      op_end_reg    <= op_end_next;
      result_reg    <= result_next;
      valid_reg     <= valid_next;
      br_reg        <= br_next;
      wr_reg        <= wr_next;
      rd_reg        <= rd_next;
      end_reg       <= end_next;
      fault_reg     <= fault_next;
    end
  end

  assign mem_result            = result_reg;
  assign mem_result_valid      = valid_reg;
  assign result_is_branch_addr = br_reg;
  assign write_to_rd           = wr_reg;
  assign rd                    = rd_reg;
  assign should_end_program    = end_reg;
  assign mem_fault             = fault_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: the bench acts as data memory over a byte
// array and predicts each result beat from the instruction and that array.
module tb_memory_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_result, ex_store_data;
  logic [1:0]  ex_mem_op;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_write_to_rd, ex_is_branch_addr, ex_end_program;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic [63:0] mem_result;
  logic        mem_result_valid, result_is_branch_addr, write_to_rd;
  logic [4:0]  rd;
  logic        should_end_program, mem_fault;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_write_to_rd(ex_write_to_rd), .ex_is_branch_addr(ex_is_branch_addr),
    .ex_end_program(ex_end_program),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .mem_result(mem_result), .mem_result_valid(mem_result_valid),
    .result_is_branch_addr(result_is_branch_addr), .write_to_rd(write_to_rd), .rd(rd),
    .should_end_program(should_end_program), .mem_fault(mem_fault)
  );

  int         tests = 0;
  int         errors = 0;
  logic       model_fault;
  logic [7:0] bmem [0:63];   // bytes 0x1000..0x103F

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word_at(input logic [63:0] addr);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = bmem[int'(addr[5:3]) * 8 + b];
    return w;
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] addr, input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int b = 0; b < n; b++) v = v | ({56'd0, bmem[int'(addr[5:0]) + b]} << (8 * b));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic check_beat(input logic [63:0] res, input logic chk_res, input logic [4:0] r,
                            input logic wr, input logic br, input logic en);
    check("valid", {63'd0, mem_result_valid}, 64'd1);
    if (chk_res) check("result", mem_result, res);
    check("rd", {59'd0, rd}, {59'd0, r});
    check("write_to_rd", {63'd0, write_to_rd}, {63'd0, wr});
    check("branch", {63'd0, result_is_branch_addr}, {63'd0, br});
    check("end_prog", {63'd0, should_end_program}, {63'd0, en});
    check("fault", {63'd0, mem_fault}, {63'd0, model_fault});
    check("ready_beat", {63'd0, ex_ready}, 64'd1);
  endtask

  // One full instruction; rdel < 0 means rvalid never comes
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] data, input logic [4:0] r, input logic wr,
                       input logic br, input logic en, input int gd, input int rdel);
    logic is_mem, mis, store;
    int n;
    logic [7:0] strb;
    is_mem = (op == 2'd1) || (op == 2'd2);
    store  = (op == 2'd2);
    n      = 1 << f3[1:0];
    mis    = is_mem && ((addr % 64'(n)) != 0);
    strb   = '0;
    for (int b = 0; b < n; b++) strb[int'(addr[2:0]) + b] = store && !mis;
    $display("[TB] op=%0d f3=%0d addr=0x%h rd=%0d gnt_dly=%0d rv_dly=%0d", op, f3, addr, r, gd, rdel);
    check("ready_idle", {63'd0, ex_ready}, 64'd1);
    ex_valid = 1'b1; ex_mem_op = op; ex_funct3 = f3; ex_result = addr; ex_store_data = data;
    ex_rd = r; ex_write_to_rd = wr; ex_is_branch_addr = br; ex_end_program = en;
    step();
    ex_valid = 1'b0;
    if (!is_mem || mis) begin
      if (mis) model_fault = 1'b1;
      check("no_req", {63'd0, dmem_req}, 64'd0);
      check_beat(addr, !mis, r, mis ? 1'b0 : wr, br, mis ? 1'b1 : en);
      return;
    end
    for (int i = 0; i < gd; i++) begin
      check("req_hold", {63'd0, dmem_req}, 64'd1);
      check("ready_busy", {63'd0, ex_ready}, 64'd0);
      check("no_beat_req", {63'd0, mem_result_valid}, 64'd0);
      step();
    end
    check("req", {63'd0, dmem_req}, 64'd1);
    check("addr", dmem_addr, {addr[63:3], 3'b000});
    check("we", {63'd0, dmem_we}, {63'd0, store});
    check("wstrb", {56'd0, dmem_wstrb}, {56'd0, strb});
    if (store) check("wdata", dmem_wdata, data << (8 * int'(addr[2:0])));
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    if (store) begin
      for (int b = 0; b < n; b++) bmem[int'(addr[5:0]) + b] = data[8*b +: 8];
      check_beat(addr, 1'b1, r, 1'b0, br, en);
      return;
    end
    for (int i = 0; i < (rdel < 0 ? TO : rdel); i++) begin
      check("wait_no_req", {63'd0, dmem_req}, 64'd0);
      check("no_beat_wait", {63'd0, mem_result_valid}, 64'd0);
      step();
    end
    if (rdel < 0) begin
      model_fault = 1'b1;
      check_beat(addr, 1'b0, r, 1'b0, br, 1'b1);
    end else begin
      dmem_rvalid = 1'b1;
      dmem_rdata  = word_at(addr);
      step();
      dmem_rvalid = 1'b0;
      dmem_rdata  = {$urandom, $urandom};
      check_beat(exp_load(addr, f3), 1'b1, r, wr, br, en);
    end
  endtask

  initial begin
    logic [1:0] op;
    logic [2:0] f3;
    logic [63:0] a;
    rst = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0; ex_mem_op = '0;
    ex_funct3 = '0; ex_rd = '0; ex_write_to_rd = 1'b0; ex_is_branch_addr = 1'b0;
    ex_end_program = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    model_fault = 1'b0;
    for (int i = 0; i < 64; i++) bmem[i] = 8'($urandom);
    step(); step();
    rst = 1'b0;
    check("rst_outs", {mem_result, 59'd0, rd}, 128'd0);
    check("rst_flags", {58'd0, mem_result_valid, result_is_branch_addr, write_to_rd,
                        should_end_program, mem_fault, dmem_req}, 64'd0);
    check("rst_ready", {63'd0, ex_ready}, 64'd1);

    // ALU op then back-to-back pair
    issue(2'd0, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 0);
    $display("[TB] back-to-back ALU pair");
    ex_valid = 1'b1; ex_mem_op = 2'd0; ex_result = 64'hAAAA; ex_rd = 5'd1; ex_write_to_rd = 1'b1;
    ex_is_branch_addr = 1'b0; ex_end_program = 1'b0;
    step();
    check("b2b_1", {mem_result_valid, 58'd0, rd, mem_result}, {1'b1, 58'd0, 5'd1, 64'hAAAA});
    ex_result = 64'hBBBB; ex_rd = 5'd2; ex_is_branch_addr = 1'b1;
    step();
    ex_valid = 1'b0;
    check("b2b_2", {mem_result_valid, result_is_branch_addr, 57'd0, rd, mem_result},
          {1'b1, 1'b1, 57'd0, 5'd2, 64'hBBBB});
    step();
    check("b2b_idle", {63'd0, mem_result_valid}, 64'd0);

    // LB / LBU at 0x1003 with word 0x00000000_80000000
    for (int b = 0; b < 8; b++) bmem[b] = 8'h00;
    bmem[3] = 8'h80;
    issue(2'd1, 3'd0, 64'h1003, 64'd0, 5'd7, 1'b1, 1'b0, 1'b0, 0, 0);
    check("lb_val", mem_result, 64'hFFFF_FFFF_FFFF_FF80);
    issue(2'd1, 3'd4, 64'h1003, 64'd0, 5'd7, 1'b1, 1'b0, 1'b0, 0, 0);
    check("lbu_val", mem_result, 64'h80);
    // SH at 0x1006, gnt after 3 cycles
    issue(2'd2, 3'd1, 64'h1006, 64'hBEEF, 5'd3, 1'b1, 1'b0, 1'b0, 3, 0);
    // Misaligned LW, then load timeout
    issue(2'd1, 3'd2, 64'h1002, 64'd0, 5'd9, 1'b1, 1'b0, 1'b0, 0, 0);
    issue(2'd1, 3'd3, 64'h1010, 64'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1, -1);
    check("to_idle", {63'd0, ex_ready}, 64'd1);

    // Reset while in WAIT
    $display("[TB] reset during WAIT");
    ex_valid = 1'b1; ex_mem_op = 2'd1; ex_funct3 = 3'd3; ex_result = 64'h1008; ex_rd = 5'd6;
    step();
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; model_fault = 1'b0;
    check("rstw_outs", {mem_result, 59'd0, rd}, 128'd0);
    check("rstw_flags", {58'd0, mem_result_valid, result_is_branch_addr, write_to_rd,
                         should_end_program, mem_fault, dmem_req}, 64'd0);
    check("rstw_ready", {63'd0, ex_ready}, 64'd1);
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    check("rstw_late_rv", {63'd0, mem_result_valid}, 64'd0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      op = 2'($urandom_range(0, 3));
      f3 = (op == 2'd2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      a  = (op == 2'd1 || op == 2'd2) ? 64'h1000 + 64'($urandom_range(0, 63)) : {$urandom, $urandom};
      issue(op, f3, a, {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
